mips_multicycle_core: RTL and testbench

//  Multi-cycle 32-bit MIPS core: the successor to the single-cycle top, with one shared memory port.
//  - Fetch, decode, execute, memory and writeback are FSM states instead of one combinational cycle.
//  - Instruction and data accesses share one req/ready memory port, so external memory may stall.
//  - Contains PC, IR, 32x32 register file, ALU, and a memory wait-watchdog.

---
 rtl/mips_multicycle_core.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// mips_multicycle_core : multi-cycle MIPS core with one shared req/ready port
// Optional macro MIPS_ILLEGAL_TRAP_EN halts on unsupported encodings. Rev 1.0
// ============================================================================
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          WAIT_LIMIT = 16,
   parameter int          CNT_W      = 5
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc_out,
   output logic        retire,
   output logic        halted,
   output logic        timeout
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] C_OP_RTYPE = 6'h00, C_OP_J    = 6'h02, C_OP_JAL  = 6'h03;
   localparam logic [5:0] C_OP_BEQ   = 6'h04, C_OP_BNE  = 6'h05, C_OP_ADDI = 6'h08;
   localparam logic [5:0] C_OP_SLTI  = 6'h0A, C_OP_ANDI = 6'h0C, C_OP_ORI  = 6'h0D;
   localparam logic [5:0] C_OP_LW    = 6'h23, C_OP_SW   = 6'h2B;
   localparam logic [5:0] C_F_SLL = 6'h00, C_F_SRL = 6'h02, C_F_JR  = 6'h08, C_F_BRK = 6'h0D;
   localparam logic [5:0] C_F_ADD = 6'h20, C_F_SUB = 6'h22, C_F_AND = 6'h24, C_F_OR  = 6'h25;
   localparam logic [5:0] C_F_SLT = 6'h2A;
   localparam logic [CNT_W-1:0] C_LIMIT_M1 = CNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [31:0]       imm_q, imm_d, target_q, target_d, alu_q, alu_d, mdr_q, mdr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_q, timeout_d, go_q, go_d;
   logic [31:0]       rf_q [32];
   logic              rf_we;
   logic [4:0]        rf_wa;
   logic [31:0]       rf_wd;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] sext_imm, rs_val, rt_val, b_op, alu_res;
   logic        is_r, op_add, op_sub, op_and, op_or, op_slt, op_sll, op_srl, op_jr, op_brk;
   logic        op_addi, op_andi, op_ori, op_slti, op_lw, op_sw, op_beq, op_bne, op_j, op_jal;
   logic        legal;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign shamt    = ir_q[10:6];
   assign funct    = ir_q[5:0];
   assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
   assign rs_val   = rf_q[rs];
   assign rt_val   = rf_q[rt];

   always_comb begin
      is_r    = (opcode == C_OP_RTYPE);
      op_add  = is_r && (funct == C_F_ADD);
      op_sub  = is_r && (funct == C_F_SUB);
      op_and  = is_r && (funct == C_F_AND);
      op_or   = is_r && (funct == C_F_OR);
      op_slt  = is_r && (funct == C_F_SLT);
      op_sll  = is_r && (funct == C_F_SLL);
      op_srl  = is_r && (funct == C_F_SRL);
      op_jr   = is_r && (funct == C_F_JR);
      op_brk  = is_r && (funct == C_F_BRK);
      op_addi = (opcode == C_OP_ADDI);
      op_andi = (opcode == C_OP_ANDI);
      op_ori  = (opcode == C_OP_ORI);
      op_slti = (opcode == C_OP_SLTI);
      op_lw   = (opcode == C_OP_LW);
      op_sw   = (opcode == C_OP_SW);
      op_beq  = (opcode == C_OP_BEQ);
      op_bne  = (opcode == C_OP_BNE);
      op_j    = (opcode == C_OP_J);
      op_jal  = (opcode == C_OP_JAL);
      legal   = op_add | op_sub | op_and | op_or | op_slt | op_sll | op_srl | op_jr | op_brk |
                op_addi | op_andi | op_ori | op_slti | op_lw | op_sw | op_beq | op_bne |
                op_j | op_jal;
   end

   // andi/ori take the zero-extended immediate; shifts operate on rt.
   always_comb begin
      b_op = imm_q;
      if (is_r) begin
         b_op = b_q;
      end else if (op_andi || op_ori) begin
         b_op = {16'h0000, ir_q[15:0]};
      end
      alu_res = a_q + b_op;
      if (op_sub) begin
         alu_res = a_q - b_op;
      end else if (op_and || op_andi) begin
         alu_res = a_q & b_op;
      end else if (op_or || op_ori) begin
         alu_res = a_q | b_op;
      end else if (op_slt || op_slti) begin
         alu_res = {31'b0, $signed(a_q) < $signed(b_op)};
      end else if (op_sll) begin
         alu_res = b_q << shamt;
      end else if (op_srl) begin
         alu_res = b_q >> shamt;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      imm_d     = imm_q;
      target_d  = target_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      go_d      = 1'b1;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      retire    = 1'b0;
      rf_we     = 1'b0;
      rf_wa     = 5'd0;
      rf_wd     = 32'h0;

      case (state_q)
         S_FETCH: begin
            // go_q keeps the port idle for the cycle right after reset
            if (go_q) begin
               mem_req  = 1'b1;
               mem_addr = {pc_q[31:2], 2'b00};
               if (mem_ready) begin
                  ir_d    = mem_rdata;
                  pc_d    = pc_q + 32'd4;
                  state_d = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            a_d      = rs_val;
            b_d      = rt_val;
            imm_d    = sext_imm;
            target_d = pc_q + {sext_imm[29:0], 2'b00};
            if (op_j || op_jal) begin
               pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
               rf_we   = op_jal;
               rf_wa   = 5'd31;
               rf_wd   = pc_q;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (op_jr) begin
               pc_d    = rs_val;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (op_brk) begin
               state_d = S_HALT;
            end else if (!legal) begin
`ifdef MIPS_ILLEGAL_TRAP_EN
               state_d = S_HALT;
`else
               retire  = 1'b1;
               state_d = S_FETCH;
`endif
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_d = alu_res;
            if (op_beq || op_bne) begin
               if ((a_q == b_q) == op_beq) begin
                  pc_d = target_q;
               end
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (op_lw || op_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_we    = op_sw;
            mem_addr  = {alu_q[31:2], 2'b00};
            mem_wdata = op_sw ? b_q : 32'h0;
            if (mem_ready) begin
               if (op_lw) begin
                  mdr_d   = mem_rdata;
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            rf_wa   = is_r ? rd : rt;
            rf_wd   = op_lw ? mdr_q : alu_q;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_HALT;
         end
      endcase

      // Watchdog overrides whatever the access state decided.
      if (mem_req) begin
         if (mem_ready) begin
            cnt_d = '0;
         end else if ((WAIT_LIMIT != 0) && (cnt_q == C_LIMIT_M1)) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
            state_d   = S_HALT;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         imm_q     <= '0;
         target_q  <= '0;
         alu_q     <= '0;
         mdr_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         go_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         imm_q     <= imm_d;
         target_q  <= target_d;
         alu_q     <= alu_d;
         mdr_q     <= mdr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         go_q      <= go_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else if (rf_we && (rf_wa != 5'd0)) begin
         rf_q[rf_wa] <= rf_wd;
      end
   end

   assign pc_out  = pc_q;
   assign halted  = (state_q == S_HALT);
   assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`default_nettype none
// tb_mips_multicycle_core : directed programs against a shared-port memory model
// with programmable data-access stall and a tie-off for the watchdog case.
module tb_mips_multicycle_core;
   localparam logic [31:0] C_RESET_PC = 32'h0000_0040;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req, mem_we, mem_ready, retire, halted, timeout;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

   logic [31:0] mem [0:255];
   int          wcnt = 0;
   int          data_delay = 0;
   bit          tie0 = 1'b0;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_ret, n_st, n_req20, hold_err, align_err, halt_cyc;
   int          ret_cyc [0:127];
   logic [31:0] st_addr [0:15];
   logic [31:0] st_data [0:15];
   logic [31:0] pc_at   [0:255];
   logic [31:0] first_addr;

   mips_multicycle_core #(
      .RESET_PC   (C_RESET_PC),
      .WAIT_LIMIT (16),
      .CNT_W      (5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc_out    (pc_out),
      .retire    (retire),
      .halted    (halted),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   // Program space (>= 0x40) is zero-wait; data space stalls data_delay cycles.
   always_comb begin
      mem_ready = mem_req && !tie0 && ((mem_addr >= 32'h40) || (wcnt >= data_delay));
      mem_rdata = mem[mem_addr[9:2]];
   end

   always @(posedge clk) begin
      if (mem_req && !mem_ready) wcnt <= wcnt + 1;
      else                       wcnt <= 0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   task automatic put(input logic [31:0] addr, input logic [31:0] word);
      mem[addr[9:2]] = word;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_req",   {31'b0, mem_req}, 32'd0);
      check("rst_pc",    pc_out, C_RESET_PC);
      check("rst_flags", {28'b0, mem_we, retire, halted, timeout}, 32'd0);
      check("rst_addr",  mem_addr, 32'd0);
      reset = 1'b0;
   endtask

   // Steps until halted; cycle 1 is the first cycle with mem_req after reset.
   task automatic run(input string tag, input int max_cyc);
      int   cyc;
      bit   started, prev_req, prev_rdy, prev_we;
      logic [31:0] prev_addr, prev_wd;
      n_ret = 0; n_st = 0; n_req20 = 0; hold_err = 0; align_err = 0; halt_cyc = 0;
      cyc = 0; started = 0; prev_req = 0; prev_rdy = 0; prev_we = 0;
      prev_addr = 0; prev_wd = 0; first_addr = 32'hFFFF_FFFF;
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge clk);
         if (mem_req && !started) begin
            started    = 1;
            first_addr = mem_addr;
         end
         if (started) begin
            cyc++;
            if (cyc < 256) pc_at[cyc] = pc_out;
            if (retire && n_ret < 128) begin
               ret_cyc[n_ret] = cyc;
               n_ret++;
            end
            if (mem_req && prev_req && !prev_rdy &&
                (mem_addr != prev_addr || mem_we != prev_we || (mem_we && mem_wdata != prev_wd)))
               hold_err++;
            if (mem_req && mem_addr[1:0] != 2'b00) align_err++;
            if (mem_req && !mem_we && mem_addr == 32'h20) n_req20++;
            if (mem_req && mem_we && mem_ready) begin
               if (n_st < 16) begin
                  st_addr[n_st] = mem_addr;
                  st_data[n_st] = mem_wdata;
               end
               n_st++;
               mem[mem_addr[9:2]] = mem_wdata;
            end
            prev_req = mem_req; prev_rdy = mem_ready; prev_we = mem_we;
            prev_addr = mem_addr; prev_wd = mem_wdata;
            if (halted) begin
               halt_cyc = cyc;
               break;
            end
         end
      end
      check({tag, "_halt_reached"}, {31'b0, halted}, 32'd1);
   endtask

   initial begin
      // Reset vector, then straight-line ALU + store
      clear_mem();
      put(32'h40, 32'h20010005);   // addi $1,$0,5
      put(32'h44, 32'h20020007);   // addi $2,$0,7
      put(32'h48, 32'h00221820);   // add  $3,$1,$2
      put(32'h4C, 32'hAC030010);   // sw   $3,0x10($0)
      put(32'h50, 32'h0000000D);   // break
      do_reset();
      run("t2", 100);
      check("t1_first_addr", first_addr, 32'h40);
      check("t1_pc_after_fetch", pc_at[2], 32'h44);
      check("t2_retires", n_ret, 4);
      check("t2_ret0_cyc", ret_cyc[0], 4);
      check("t2_ret3_cyc", ret_cyc[3], 16);
      check("t2_st_addr", st_addr[0], 32'h10);
      check("t2_st_data", st_data[0], 32'd12);
      check("t2_halt_cyc", halt_cyc, 19);
      check("t2_no_timeout", {31'b0, timeout}, 32'd0);

      // Stalled load, forwarded to a store
      clear_mem();
      put(32'h20, 32'hDEADBEEF);
      put(32'h40, 32'h8C040020);   // lw $4,0x20($0)
      put(32'h44, 32'hAC040024);   // sw $4,0x24($0)
      put(32'h48, 32'h0000000D);
      data_delay = 3;
      do_reset();
      run("t3", 100);
      check("t3_lw_ret_cyc", ret_cyc[0], 8);
      check("t3_lw_req_cycles", n_req20, 4);
      check("t3_hold", hold_err, 0);
      check("t3_st_data", st_data[0], 32'hDEADBEEF);
      check("t3_st_addr", st_addr[0], 32'h24);
      data_delay = 0;

      // Jumps, branches, jal link, misaligned load
      clear_mem();
      put(32'h28, 32'h12345678);
      put(32'h40, 32'h0C000018);   // jal 0x60
      put(32'h44, 32'hAC1F0030);   // sw  $31,0x30($0)
      put(32'h48, 32'h14000005);   // bne $0,$0,+5 (not taken)
      put(32'h4C, 32'h8C06002B);   // lw  $6,0x2B($0)
      put(32'h50, 32'hAC060034);   // sw  $6,0x34($0)
      put(32'h54, 32'h0000000D);
      put(32'h60, 32'h0800001A);   // j 0x68
      put(32'h64, 32'h03E00008);   // jr $31
      put(32'h68, 32'h1000FFFE);   // beq $0,$0,-2
      do_reset();
      run("t4", 200);
      check("t4_retires", n_ret, 8);
      check("t4_jal_cyc", ret_cyc[0], 2);
      check("t4_jal_pc", pc_at[3], 32'h60);
      check("t4_beq_cyc", ret_cyc[2], 7);
      check("t4_beq_pc", pc_at[8], 32'h64);
      check("t4_bne_cyc", ret_cyc[5], 16);
      check("t4_bne_pc", pc_at[17], 32'h4C);
      check("t4_last_cyc", ret_cyc[7], 25);
      check("t4_link", st_data[0], 32'h44);
      check("t4_mis_data", st_data[1], 32'h12345678);
      check("t4_align", align_err, 0);

      // Full ALU coverage stored to 0x00..0x1C
      clear_mem();
      put(32'h40, 32'h2001FFFD);   // addi $1,$0,-3
      put(32'h44, 32'h34028001);   // ori  $2,$0,0x8001
      put(32'h48, 32'h00411822);   // sub  $3,$2,$1
      put(32'h4C, 32'h00222024);   // and  $4,$1,$2
      put(32'h50, 32'h00222825);   // or   $5,$1,$2
      put(32'h54, 32'h0022302A);   // slt  $6,$1,$2
      put(32'h58, 32'h00023900);   // sll  $7,$2,4
      put(32'h5C, 32'h00014702);   // srl  $8,$1,28
      put(32'h60, 32'h3029FFF0);   // andi $9,$1,0xFFF0
      put(32'h64, 32'h282AFFFE);   // slti $10,$1,-2
      for (int k = 0; k < 8; k++)
         put(32'h68 + 32'(4 * k), 32'hAC000000 | (32'(k + 3) << 16) | 32'(4 * k));
      put(32'h88, 32'h0000000D);
      do_reset();
      run("t7", 300);
      check("t7_stores", n_st, 8);
      check("t7_sub",  mem[0], 32'h00008004);
      check("t7_and",  mem[1], 32'h00008001);
      check("t7_or",   mem[2], 32'hFFFFFFFD);
      check("t7_slt",  mem[3], 32'h00000001);
      check("t7_sll",  mem[4], 32'h00080010);
      check("t7_srl",  mem[5], 32'h0000000F);
      check("t7_andi", mem[6], 32'h0000FFF0);
      check("t7_slti", mem[7], 32'h00000001);
      check("t7_halt_cyc", halt_cyc, 75);

      // Unsupported opcode, $0 write discard
      clear_mem();
      put(32'h40, 32'h20010009);   // addi $1,$0,9
      put(32'h44, 32'hFC000000);   // opcode 0x3F
      put(32'h48, 32'h20000005);   // addi $0,$0,5
      put(32'h4C, 32'hAC010038);   // sw $1,0x38($0)
      put(32'h50, 32'hAC00003C);   // sw $0,0x3C($0)
      put(32'h54, 32'h0000000D);
      do_reset();
      run("t6", 100);
`ifdef MIPS_ILLEGAL_TRAP_EN
      check("t6_trap_retires", n_ret, 1);
      check("t6_trap_pc", pc_out, 32'h48);
      check("t6_trap_cyc", halt_cyc, 7);
`else
      check("t6_nop_retires", n_ret, 5);
      check("t6_nop_cyc", ret_cyc[1], 6);
      check("t6_r1", st_data[0], 32'd9);
      check("t6_r0", st_data[1], 32'd0);
`endif

      // Watchdog with memory never ready
      tie0 = 1'b1;
      do_reset();
      run("t5", 60);
      check("t5_halt_cyc", halt_cyc, 17);
      check("t5_timeout", {31'b0, timeout}, 32'd1);
      check("t5_req_low", {31'b0, mem_req}, 32'd0);
      @(negedge clk);
      check("t5_still_halted", {30'b0, halted, mem_req}, 32'd2);
      do_reset();
      check("t5_cleared", {30'b0, halted, timeout}, 32'd0);
      repeat (3) @(negedge clk);
      check("t5_req_waiting", {31'b0, mem_req}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("t5_rst_drop", {31'b0, mem_req}, 32'd0);
      check("t5_rst_pc", pc_out, C_RESET_PC);
      reset = 1'b0;
      tie0 = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
